des_dec_key_sched: RTL and testbench
====================================

Name: des_dec_key_sched

Overview:
- Sequential DES key schedule for the decryption direction.
- Accepts one 64-bit DES key and emits the 16 48-bit round subkeys in reverse order: K16 first, K1 last.
- Uses right rotations, so no 16-entry subkey store is needed.
- Sits ahead of the Feistel round datapath (the S-box LUTs consume subkey XOR E(R)) when the core runs in decrypt mode.

Parameters:
- None. DES constants (PC-1, PC-2, shift schedule) are fixed by FIPS 46-3.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- key  input  64  DES key; key[63] = DES bit 1, key[0] = bit 64. Parity bits 8,16,…,64 are ignored.
- key_valid  input  1  key is presented.
- key_ready  output  1  block can accept a key (IDLE only).
- subkey  output  48  current round subkey; subkey[47] = PC-2 output bit 1.
- subkey_idx  output  5  DES round number of subkey, 16 down to 1.
- subkey_last  output  1  high while subkey_idx == 1 and subkey_valid is high.
- subkey_valid  output  1  subkey is valid.
- subkey_ready  input  1  consumer accepts subkey.

Behaviour:
- State registers:
  - C, D: 28 bits each.
  - cnt: 5 bits.
  - FSM with states IDLE and RUN.
- Reset (synchronous, any state, including mid-sequence):
  - FSM = IDLE; C = D = 0; cnt = 0.
  - key_ready = 1, subkey_valid = 0, subkey_last = 0, subkey_idx = 0, subkey = 0.
  - A partially emitted sequence is abandoned.
- Output derivation:
  - subkey = PC2(C,D), combinational from the registers.
  - subkey_idx = cnt.
  - subkey_valid = (state == RUN).
  - key_ready = (state == IDLE).
- IDLE:
  - On key_valid && key_ready: {C,D} <= PC1(key), cnt <= 16, state goes to RUN.
  - No other state change.
- RUN:
  - On subkey_valid && subkey_ready with cnt > 1: {C,D} <= right-rotate each half by R(cnt), cnt <= cnt - 1.
  - On the handshake with cnt == 1: state goes to IDLE; C, D and cnt are cleared to 0.
  - Without a handshake, subkey, subkey_idx and subkey_last hold stable. Backpressure may last any number of cycles.
- Rotation amounts R(cnt), applied when leaving round cnt. These are the encryption left-shift amounts of round cnt, applied in reverse:
  - cnt 16, 9, 2: rotate by 1.
  - All other cnt in 15..3: rotate by 2.
  - Total over the sequence = 27, so C1/D1 are reached correctly. C16 = C0 because the encryption left shifts sum to 28.
- Latency and throughput:
  - Key accepted in cycle N: K16 is valid in cycle N+1.
  - With subkey_ready held high, K(17-i) appears in cycle N+i, and K1 in cycle N+16.
  - key_ready is high again in cycle N+17, giving one key per 17 cycles.
- key_valid during RUN is ignored; the key is not sampled and key_ready stays 0.
- No back-to-back overlap: the final subkey handshake and a new key acceptance never share a cycle.
- Widths: all rotations are modulo 28 within each half. cnt never wraps below 1 while in RUN.

Test Plan:
- Key 0x133457799BBCDFF1, subkey_ready=1:
  - subkey_valid high for exactly 16 consecutive cycles.
  - First output idx 16, subkey 0xCB3D8B0E17F5.
  - Second output idx 15.
  - Fifteenth output idx 2, subkey 0x79AED9DBC9E5.
  - Sixteenth output idx 1, subkey 0x1B02EFFC7072, subkey_last=1.
  - key_ready=1 on the following cycle.
- Same key with random subkey_ready stalls (0-5 cycles):
  - Subkey, idx and last stay constant during each stall.
  - Accepted sequence is identical to the previous case.
  - All 16 subkeys match a golden software model run in reverse order.
- Key 0x0000000000000000: all 16 subkeys = 0.
- Parity test: key 0x0101010101010101 yields all subkeys 0. Flipping any parity bit (e.g. 0x133457799BBCDFF0 vs …F1) produces identical subkeys.
- Key_valid pulsed with a different key while in RUN at idx 10: ignored, and the remaining subkeys follow the original key.
- Reset asserted at idx 7: the next cycle shows key_ready=1, subkey_valid=0, subkey=0, idx=0. A fresh key then starts at idx 16 with the correct K16.

Source files
------------

// File: rtl/des_dec_key_sched.sv
// -----------------------------------------------------------------------------
// des_dec_key_sched
//
// Sequential DES key schedule for the decryption direction. One 64-bit key is
// accepted and the 16 round subkeys are streamed out in reverse order, K16
// first and K1 last. K16 is derived from C16/D16, which equal C0/D0 because
// the encryption left shifts add up to a full 28-bit turn. Each later subkey
// is reached by rotating each half right by that round's encryption shift
// amount, so no subkey store is needed.
//
// Ports
//   clk           system clock, rising-edge active
//   rst           synchronous active-high reset
//   key           DES key, key[63] = DES bit 1 ... key[0] = DES bit 64;
//                 parity bits 8,16,...,64 are never referenced by PC-1
//   key_valid     a key is presented
//   key_ready     block can accept a key (IDLE only)
//   subkey        current round subkey, subkey[47] = PC-2 output bit 1
//   subkey_idx    DES round number of subkey, 16 down to 1
//   subkey_last   high with the round-1 subkey
//   subkey_valid  subkey is valid
//   subkey_ready  consumer accepts the subkey
// -----------------------------------------------------------------------------
module des_dec_key_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] key,
   input  logic        key_valid,
   output logic        key_ready,
   output logic [47:0] subkey,
   output logic [4:0]  subkey_idx,
   output logic        subkey_last,
   output logic        subkey_valid,
   input  logic        subkey_ready
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // PC-1: entry i names the DES key bit (1..64) that lands in C/D bit i+1.
   localparam int PC1_TBL [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   // PC-2: entry j names the C/D bit (1..56) that lands in subkey bit j+1.
   localparam int PC2_TBL [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   // DES numbers bits from the MSB, so DES bit b of an N-bit vector is [N-b].
   function automatic logic [55:0] pc1 (input logic [63:0] k);
      logic [55:0] cd;
      cd = '0;
      for (int i = 0; i < 56; i++) begin
         cd[6'(55 - i)] = k[6'(64 - PC1_TBL[6'(i)])];
      end
      return cd;
   endfunction

   function automatic logic [47:0] pc2 (input logic [55:0] cd);
      logic [47:0] ks;
      ks = '0;
      for (int j = 0; j < 48; j++) begin
         ks[6'(47 - j)] = cd[6'(56 - PC2_TBL[6'(j)])];
      end
      return ks;
   endfunction

   // Right rotation of one 28-bit half by 1 or 2 places.
   function automatic logic [27:0] ror28 (input logic [27:0] x, input logic by_two);
      return by_two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   state_t      state_q, state_d;
   logic [27:0] c_q, c_d;
   logic [27:0] d_q, d_d;
   logic [4:0]  cnt_q, cnt_d;

   logic        handshake;
   logic        rot_by_two;

   // Outputs are pure functions of the registers; after reset C = D = 0 makes
   // subkey read 0 without any extra gating.
   assign key_ready    = (state_q == IDLE);
   assign subkey_valid = (state_q == RUN);
   assign subkey_idx   = cnt_q;
   assign subkey       = pc2({c_q, d_q});
   assign subkey_last  = subkey_valid && (cnt_q == 5'd1);

   assign handshake    = subkey_valid && subkey_ready;

   // Leaving round cnt undoes that round's encryption left shift: rounds 16,
   // 9 and 2 shifted by one place, every other round by two. Round 1's shift
   // is never undone, so the sequence ends on C1/D1.
   assign rot_by_two   = !((cnt_q == 5'd16) || (cnt_q == 5'd9) || (cnt_q == 5'd2));

   always_comb begin
      // NOTE: every _d signal holds its register value unless a branch below
      // overrides it, so no path through this block can infer a latch.
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (key_valid && key_ready) begin
               {c_d, d_d} = pc1(key);
               cnt_d      = 5'd16;
               state_d    = RUN;
            end
         end

         RUN: begin
            // key_valid is deliberately not looked at here.
            if (handshake) begin
               if (cnt_q == 5'd1) begin
                  state_d = IDLE;
                  c_d     = '0;
                  d_d     = '0;
                  cnt_d   = '0;
               end else begin
                  c_d   = ror28(c_q, rot_by_two);
                  d_d   = ror28(d_q, rot_by_two);
                  cnt_d = cnt_q - 5'd1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples its _d
   // value from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         c_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_des_dec_key_sched.sv
// -----------------------------------------------------------------------------
// tb_des_dec_key_sched
//
// Scoreboard bench for des_dec_key_sched. The stimulus process computes the
// full forward (encryption) key schedule in software, stores all 16 subkeys
// and pushes them onto the scoreboard in reverse order. A monitor compares the
// presented subkey against the scoreboard head every valid cycle (so stalls
// must hold the value) and pops on each handshake.
// -----------------------------------------------------------------------------
module tb_des_dec_key_sched;

   localparam logic [63:0] GOLD_KEY = 64'h1334_5779_9BBC_DFF1;
   localparam logic [47:0] GOLD_K16 = 48'hCB3D_8B0E_17F5;
   localparam logic [47:0] GOLD_K2  = 48'h79AE_D9DB_C9E5;
   localparam logic [47:0] GOLD_K1  = 48'h1B02_EFFC_7072;

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   typedef struct packed {
      logic [47:0] sk;
      logic [4:0]  idx;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] key;
   logic        key_valid;
   logic        key_ready;
   logic [47:0] subkey;
   logic [4:0]  subkey_idx;
   logic        subkey_last;
   logic        subkey_valid;
   logic        subkey_ready;

   exp_t        sb_q [$];
   logic [47:0] model_ks [$];   // model_ks[r-1] = encryption subkey K_r
   int          total = 0;
   int          bad   = 0;

   des_dec_key_sched dut (
      .clk          (clk),
      .rst          (rst),
      .key          (key),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .subkey       (subkey),
      .subkey_idx   (subkey_idx),
      .subkey_last  (subkey_last),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready)
   );

   always #5 clk = ~clk;

   task automatic check (input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Forward DES key schedule: PC-1, left rotations per round, PC-2.
   task automatic model_schedule (input logic [63:0] k);
      logic [27:0] c;
      logic [27:0] d;
      logic [55:0] cd;
      logic [47:0] ks;
      int          s;
      c = '0;
      d = '0;
      for (int i = 0; i < 28; i++) begin
         c = {c[26:0], 1'(k >> (64 - PC1_T[6'(i)]))};
         d = {d[26:0], 1'(k >> (64 - PC1_T[6'(i + 28)]))};
      end
      model_ks.delete();
      for (int r = 0; r < 16; r++) begin
         s  = SHIFT_T[4'(r)];
         c  = (c << s) | (c >> (28 - s));
         d  = (d << s) | (d >> (28 - s));
         cd = {c, d};
         ks = '0;
         for (int j = 0; j < 48; j++) begin
            ks = {ks[46:0], 1'(cd >> (56 - PC2_T[6'(j)]))};
         end
         model_ks.push_back(ks);
      end
   endtask

   // Expected decrypt stream: K16 .. K1 of src_key, or all-zero subkeys.
   task automatic push_expected (input logic [63:0] src_key, input bit all_zero);
      exp_t e;
      model_schedule(src_key);
      for (int r = 16; r >= 1; r--) begin
         e.sk   = all_zero ? 48'h0 : model_ks[r - 1];
         e.idx  = 5'(r);
         e.last = (r == 1);
         sb_q.push_back(e);
      end
   endtask

   // Presents k for one accepted cycle; returns at posedge+1 after acceptance.
   task automatic send_key (input logic [63:0] k, input logic [63:0] src_key, input bit all_zero);
      int budget = 60;
      while (!key_ready && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      check("key_ready_wait", 64'(key_ready), 64'd1);
      if (key_ready) begin
         push_expected(src_key, all_zero);
         key       = k;
         key_valid = 1'b1;
         @(posedge clk); #1;
         key_valid = 1'b0;
         key       = {$urandom, $urandom};
      end
   endtask

   // Runs the consumer until the scoreboard empties, optionally with 0-5
   // cycle stalls between accepted subkeys.
   task automatic drain (input bit stalls);
      int budget = 400;
      int stall_left = 0;
      while (sb_q.size() != 0 && budget > 0) begin
         if (stalls && stall_left > 0) begin
            subkey_ready = 1'b0;
            stall_left--;
         end else begin
            subkey_ready = 1'b1;
            stall_left   = stalls ? $urandom_range(0, 5) : 0;
         end
         @(posedge clk); #1;
         budget--;
      end
      subkey_ready = 1'b1;
      check("drain_left", 64'(sb_q.size()), 64'd0);
   endtask

   task automatic wait_idx (input logic [4:0] target);
      int budget = 100;
      while (!(subkey_valid && subkey_idx == target) && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      check("reach_idx", 64'(subkey_idx), 64'(target));
   endtask

   // Monitor: compare every valid cycle against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && subkey_valid) begin
            check("key_ready_in_run", 64'(key_ready), 64'd0);
            if (sb_q.size() == 0) begin
               check("unexpected_subkey_idx", 64'(subkey_idx), 64'd0);
            end else begin
               e = sb_q[0];
               check("subkey", 64'(subkey), 64'(e.sk));
               check("subkey_idx", 64'(subkey_idx), 64'(e.idx));
               check("subkey_last", 64'(subkey_last), 64'(e.last));
               if (subkey_ready) void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] rk;
      rst          = 1'b1;
      key          = '0;
      key_valid    = 1'b0;
      subkey_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_key_ready", 64'(key_ready), 64'd1);
      check("rst_valid", 64'(subkey_valid), 64'd0);
      check("rst_subkey", 64'(subkey), 64'd0);
      check("rst_idx", 64'(subkey_idx), 64'd0);
      check("rst_last", 64'(subkey_last), 64'd0);

      // Golden key, consumer always ready: latency and known subkeys.
      subkey_ready = 1'b1;
      send_key(GOLD_KEY, GOLD_KEY, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         check("gold_valid", 64'(subkey_valid), 64'd1);
         if (i == 1) begin
            check("gold_k16", 64'(subkey), 64'(GOLD_K16));
            check("gold_idx16", 64'(subkey_idx), 64'd16);
         end
         if (i == 2)  check("gold_idx15", 64'(subkey_idx), 64'd15);
         if (i == 15) begin
            check("gold_k2", 64'(subkey), 64'(GOLD_K2));
            check("gold_idx2", 64'(subkey_idx), 64'd2);
         end
         if (i == 16) begin
            check("gold_k1", 64'(subkey), 64'(GOLD_K1));
            check("gold_idx1", 64'(subkey_idx), 64'd1);
            check("gold_last", 64'(subkey_last), 64'd1);
         end
      end
      @(negedge clk);
      check("gold_after_ready", 64'(key_ready), 64'd1);
      check("gold_after_valid", 64'(subkey_valid), 64'd0);
      @(posedge clk); #1;
      drain(1'b0);

      // Same key under random backpressure.
      send_key(GOLD_KEY, GOLD_KEY, 1'b0);
      drain(1'b1);

      // All-zero key and all-parity key give all-zero subkeys.
      send_key(64'h0, 64'h0, 1'b1);
      drain(1'b1);
      send_key(64'h0101_0101_0101_0101, 64'h0, 1'b1);
      drain(1'b0);

      // Parity bit flipped: subkeys must match the original key's.
      send_key(64'h1334_5779_9BBC_DFF0, GOLD_KEY, 1'b0);
      drain(1'b1);

      // New key offered mid-sequence is ignored.
      subkey_ready = 1'b1;
      send_key(GOLD_KEY, GOLD_KEY, 1'b0);
      wait_idx(5'd10);
      key       = 64'hFEDC_BA98_7654_3210;
      key_valid = 1'b1;
      check("run_key_ready", 64'(key_ready), 64'd0);
      @(posedge clk); #1;
      key_valid = 1'b0;
      drain(1'b0);

      // Reset mid-sequence abandons it.
      rk = {$urandom, $urandom};
      send_key(rk, rk, 1'b0);
      wait_idx(5'd7);
      rst          = 1'b1;
      subkey_ready = 1'b0;
      sb_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_key_ready", 64'(key_ready), 64'd1);
      check("midrst_valid", 64'(subkey_valid), 64'd0);
      check("midrst_subkey", 64'(subkey), 64'd0);
      check("midrst_idx", 64'(subkey_idx), 64'd0);
      check("midrst_last", 64'(subkey_last), 64'd0);
      send_key(GOLD_KEY, GOLD_KEY, 1'b0);
      @(negedge clk);
      check("midrst_k16", 64'(subkey), 64'(GOLD_K16));
      check("midrst_idx16", 64'(subkey_idx), 64'd16);
      @(posedge clk); #1;
      drain(1'b1);

      // Random keys under random backpressure.
      for (int n = 0; n < 6; n++) begin
         rk = {$urandom, $urandom};
         send_key(rk, rk, 1'b0);
         drain(1'b1);
      end

      repeat (3) @(posedge clk);
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
